// File: rtl/instruction_prefetch.sv
`timescale 1ns/1ps
// rtl/instruction_prefetch.sv - DEPTH-entry prefetching instruction fetch unit with Wishbone read master
module instruction_prefetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_branch_enable,
   input  logic [31:0]                i_branch_address,
   input  logic                       i_stall,
   output logic                       o_wb_cyc,
   output logic                       o_wb_stb,
   output logic [31:0]                o_wb_adr,
   output logic [3:0]                 o_wb_sel,
   output logic                       o_wb_we,
   input  logic [31:0]                i_wb_dat,
   input  logic                       i_wb_ack,
   output logic [31:0]                o_instruction,
   output logic [31:0]                o_pc,
   output logic                       o_instruction_valid,
   output logic [$clog2(DEPTH+1)-1:0] o_level
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [31:0]   NOP     = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     adr_q, adr_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic            cyc_q, cyc_d;
   logic            valid_q, valid_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [PW-1:0]   rptr_q, rptr_d;
   logic [31:0]     pc_mem_q    [DEPTH];
   logic [31:0]     instr_mem_q [DEPTH];

   logic            push;
   logic            pop;
   logic            flush;
   logic [31:0]     branch_target;
   logic            unused_addr_bits;

   // Redirect targets are word aligned; the low address bits carry no meaning.
   assign branch_target    = {i_branch_address[31:2], 2'b00};
   assign unused_addr_bits = ^i_branch_address[1:0];

   assign flush = i_branch_enable;
   assign pop   = valid_q && !i_stall && !i_branch_enable;
   // Only an ack to a live request fills the queue; acks in IDLE or DISCARD are dropped.
   assign push  = (state_q == REQ) && i_wb_ack && !i_branch_enable;

   // Queue occupancy and pointer bookkeeping for this cycle's push/pop/flush.
   always_comb begin
      count_d = count_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      if (flush) begin
         count_d = '0;
         wptr_d  = '0;
         rptr_d  = '0;
      end else begin
         if (push) begin
            wptr_d = wptr_q + PTR_ONE;
         end
         if (pop) begin
            rptr_d = rptr_q + PTR_ONE;
         end
         if (push && !pop) begin
            count_d = count_q + CNT_ONE;
         end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
         end
      end
      valid_d = (count_d != '0);
   end

   // Fetch FSM: decides the next bus request, fetch address and redirect handling.
   always_comb begin
      state_d    = state_q;
      adr_d      = adr_q;
      fetch_pc_d = fetch_pc_q;
      unique case (state_q)
         IDLE: begin
            if (flush) begin
               fetch_pc_d = branch_target;
               adr_d      = branch_target;
               state_d    = REQ;
            end else if (count_d < DEPTH_C) begin
               adr_d   = fetch_pc_q;
               state_d = REQ;
            end
         end
         REQ: begin
            if (flush) begin
               fetch_pc_d = branch_target;
               if (i_wb_ack) begin
                  adr_d   = branch_target;
                  state_d = REQ;
               end else begin
                  // The outstanding cycle must complete before the new target goes out.
                  state_d = DISCARD;
               end
            end else if (i_wb_ack) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
               if (count_d < DEPTH_C) begin
                  adr_d   = fetch_pc_q + 32'd4;
                  state_d = REQ;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DISCARD: begin
            // fetch_pc doubles as the saved redirect target; a later branch overwrites it.
            if (flush) begin
               fetch_pc_d = branch_target;
            end
            if (i_wb_ack) begin
               adr_d   = fetch_pc_d;
               state_d = REQ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      cyc_d = (state_d != IDLE);
   end

   // Control and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         adr_q      <= RESET_PC;
         fetch_pc_q <= RESET_PC;
         cyc_q      <= 1'b0;
         valid_q    <= 1'b0;
         count_q    <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
      end else begin
         state_q    <= state_d;
         adr_q      <= adr_d;
         fetch_pc_q <= fetch_pc_d;
         cyc_q      <= cyc_d;
         valid_q    <= valid_d;
         count_q    <= count_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
      end
   end

   // Queue storage; reset fills it with NOPs at RESET_PC so the head reads sanely when empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= RESET_PC;
            instr_mem_q[i] <= NOP;
         end
      end else if (push) begin
         pc_mem_q[wptr_q]    <= adr_q;
         instr_mem_q[wptr_q] <= i_wb_dat;
      end
   end

   assign o_wb_cyc            = cyc_q;
   assign o_wb_stb            = cyc_q;
   assign o_wb_adr            = adr_q;
   assign o_wb_sel            = 4'hF;
   assign o_wb_we             = 1'b0;
   assign o_instruction       = instr_mem_q[rptr_q];
   assign o_pc                = pc_mem_q[rptr_q];
   assign o_instruction_valid = valid_q;
   assign o_level             = count_q;

endmodule
